// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - fetch_entry_t  : {pc, insn} pair at the default 32/32 widths
//   - FETCH_BASEADDR : default reset PC
//   - FETCH_INC      : default PC step per fetch
//   - clog2()        : ceiling log2 for sizing pointers and counters
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int          FETCH_AWIDTH   = 32;
  localparam int          FETCH_DWIDTH   = 32;
  localparam logic [31:0] FETCH_BASEADDR = 32'h0100_0000;
  localparam logic [31:0] FETCH_INC      = 32'd4;

  typedef struct packed {
    logic [FETCH_AWIDTH-1:0] pc;
    logic [FETCH_DWIDTH-1:0] insn;
  } fetch_entry_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO used for both the in-order PC tag queue and the prefetch
//   data FIFO. Flush empties it in one cycle and wins over push/pop. A push
//   into a full FIFO is accepted only if a pop happens in the same cycle; a
//   pop from an empty FIFO is ignored.
// Parameters
//   DEPTH    entries (power of 2, >= 2)
//   entry_t  stored type
// Ports
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         drop the head entry
//   flush       discard all entries
//   head        entry at the head (stale when count == 0)
//   count       number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  entry_t                push_data,
  input  logic                  pop,
  input  logic                  flush,
  output entry_t                head,
  output logic [clog2(DEPTH):0] count
);

  localparam int PW = clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only ever
  // read behind a non-zero count, so clearing it would cost logic for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Issues sequential PCs to instruction memory over
//   a valid/ready request channel, collects in-order responses into a
//   DEPTH-entry prefetch FIFO of {pc, insn} pairs and drains them to decode
//   over valid/ready. A redirect reloads the PC, flushes queued work and marks
//   every response still in flight to be discarded.
//
//   A request is only issued when (outstanding + fifo entries) < DEPTH, so
//   each response is guaranteed a FIFO slot and is always accepted.
//
// Parameters
//   DWIDTH, AWIDTH, BASEADDR (reset PC), DEPTH (power of 2, >= 2), INC
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   redirect_i/redirect_pc_i load a new PC and flush
//   req_valid_o/req_ready_i/req_addr_o   memory request channel
//   rsp_valid_i/rsp_data_i   in-order memory responses
//   pc_o/insn_o/valid_o/ready_i          decode channel (head of FIFO)
// Configuration
//   FETCH_PERF_EN  adds perf_fetched_o (pops) and perf_stall_o (cycles with
//                  ready_i && !valid_o), both saturating 32-bit counters.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DWIDTH   = FETCH_DWIDTH,
  parameter int                AWIDTH   = FETCH_AWIDTH,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(FETCH_BASEADDR),
  parameter int                DEPTH    = 4,
  parameter logic [AWIDTH-1:0] INC      = AWIDTH'(FETCH_INC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [AWIDTH-1:0] req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [DWIDTH-1:0] rsp_data_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_stall_o
`endif
);

  // Counter width able to hold 0..DEPTH.
  localparam int           CW       = clog2(DEPTH) + 1;
  localparam logic [CW:0]  DEPTH_CR = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] pc_next;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop;
  logic [CW:0]       credit_used;
  logic              issue;
  logic              rsp_keep;
  logic              pop;

  logic [AWIDTH-1:0] tag_head;
  logic [CW-1:0]     tag_count;
  entry_t            fifo_head;
  entry_t            fifo_push_data;
  logic [CW-1:0]     fifo_count;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
    req_valid_o     = !rst && !redirect_i && (credit_used < DEPTH_CR);
    req_addr_o      = pc_next;
    issue           = req_valid_o && req_ready_i;
    // A response with nothing in the tag queue can only be stale; discard it.
    rsp_keep        = rsp_valid_i && (drop == '0) && !redirect_i && (tag_count != '0);
    valid_o         = (fifo_count != '0);
    // A pop in a redirect cycle is dropped: the head is being flushed anyway.
    pop             = valid_o && ready_i && !redirect_i;
    outstanding_nxt = outstanding + CW'(issue) - CW'(rsp_valid_i);
    fifo_push_data  = '{pc: tag_head, insn: rsp_data_i};
    pc_o            = valid_o ? fifo_head.pc   : '0;
    insn_o          = valid_o ? fifo_head.insn : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_next     <= BASEADDR;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        pc_next <= redirect_pc_i;
        // Everything still in flight after this cycle belongs to the old path.
        drop    <= outstanding_nxt;
      end else begin
        if (issue) pc_next <= pc_next + INC;
        if (rsp_valid_i && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // PC of every live request, in issue order; consumed as responses arrive.
  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (logic [AWIDTH-1:0])
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (pc_next),
    .pop       (rsp_keep),
    .flush     (redirect_i),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_data_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (fifo_push_data),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (fifo_head),
    .count     (fifo_count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (pop && (perf_fetched_o != '1))
        perf_fetched_o <= perf_fetched_o + 32'd1;
      if (ready_i && !valid_o && (perf_stall_o != '1))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit with default parameters. A 1-cycle memory
//   returns insn = ~addr for every accepted request (responses can be held
//   back with mem_hold). Every pop is compared with the expected sequential PC.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic        valid_o;
  logic        ready_i;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .pc_o          (pc_o),
    .insn_o        (insn_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o(perf_fetched_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pend[$];
  bit          mem_hold = 1'b0;
  bit          chk_pops = 1'b0;
  logic [31:0] exp_pc;
  int          pops;
  int          issued;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: present the memory response, check any pop, record any
  // accepted request, then advance to just after the next rising edge.
  task automatic tick();
    if (!mem_hold && pend.size() > 0) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = ~pend[0];
    end else begin
      rsp_valid_i = 1'b0;
      rsp_data_i  = '0;
    end
    #1;
    if (chk_pops && valid_o && ready_i && !redirect_i) begin
      check("pop_pc", pc_o, exp_pc);
      check("pop_insn", insn_o, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (rsp_valid_i) void'(pend.pop_front());
    if (req_valid_o && req_ready_i) begin
      pend.push_back(req_addr_o);
      issued++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    req_ready_i   = 1'b1;
    ready_i       = 1'b0;
    rsp_valid_i   = 1'b0;
    rsp_data_i    = '0;
    pend.delete();
    mem_hold = 1'b0;
    chk_pops = 1'b0;
    pops     = 0;
    issued   = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(req_valid_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_insn", insn_o, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: free-running sequential fetch
    do_reset();
    ready_i  = 1'b1;
    chk_pops = 1'b1;
    exp_pc   = BASE;
    #1;
    check("t1_req_valid", 32'(req_valid_o), 32'd1);
    check("t1_req_addr0", req_addr_o, BASE);
    tick();
    check("t1_req_addr1", req_addr_o, BASE + 32'd4);
    repeat (11) tick();
    check("t1_pops", 32'(pops), 32'd10);

    // 2: decode stalled for 20 cycles, credits cap issue at DEPTH
    do_reset();
    repeat (20) tick();
    check("t2_issued", 32'(issued), 32'd4);
    check("t2_req_valid", 32'(req_valid_o), 32'd0);
    check("t2_valid", 32'(valid_o), 32'd1);
    check("t2_pending", 32'(pend.size()), 32'd0);
    ready_i  = 1'b1;
    chk_pops = 1'b1;
    exp_pc   = BASE;
    repeat (4) tick();
    check("t2_pops", 32'(pops), 32'd4);

    // 3: redirect with two responses in flight
    do_reset();
    mem_hold = 1'b1;
    repeat (2) tick();
    check("t3_pending", 32'(pend.size()), 32'd2);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0100_0100;
    #1;
    check("t3_redir_req_valid", 32'(req_valid_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    mem_hold   = 1'b0;
    ready_i    = 1'b1;
    chk_pops   = 1'b1;
    exp_pc     = 32'h0100_0100;
    check("t3_valid_after", 32'(valid_o), 32'd0);
    repeat (8) tick();
    check("t3_pops", 32'(pops), 32'd5);

    // 4: redirect coinciding with a response and a pop
    do_reset();
    repeat (3) tick();
    mem_hold = 1'b1;
    tick();
    mem_hold      = 1'b0;
    ready_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0200_0000;
    #1;
    check("t4_valid_before", 32'(valid_o), 32'd1);
    check("t4_pending", 32'(pend.size()), 32'd2);
    tick();
    redirect_i = 1'b0;
    check("t4_valid_after", 32'(valid_o), 32'd0);
    check("t4_pc_after", pc_o, 32'd0);
    check("t4_insn_after", insn_o, 32'd0);
    chk_pops = 1'b1;
    exp_pc   = 32'h0200_0000;
    repeat (6) tick();
    check("t4_pops", 32'(pops), 32'd4);

    // 5: PC wrap at the top of the address space
    do_reset();
    ready_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    check("t5_req_addr0", req_addr_o, 32'hFFFF_FFFC);
    chk_pops = 1'b1;
    exp_pc   = 32'hFFFF_FFFC;
    tick();
    check("t5_req_addr1", req_addr_o, 32'h0000_0000);
    repeat (5) tick();
    check("t5_pops", 32'(pops), 32'd4);

`ifdef FETCH_PERF_EN
    // 6: performance counters
    do_reset();
    check("t6_fetched_rst", perf_fetched_o, 32'd0);
    check("t6_stall_rst", perf_stall_o, 32'd0);
    ready_i     = 1'b1;
    req_ready_i = 1'b0;
    chk_pops    = 1'b1;
    exp_pc      = BASE;
    tick();
    req_ready_i = 1'b1;
    repeat (12) tick();
    ready_i = 1'b0;
    check("t6_pops", 32'(pops), 32'd10);
    check("t6_fetched", perf_fetched_o, 32'd10);
    check("t6_stall", perf_stall_o, 32'd3);
    do_reset();
    check("t6_fetched_clr", perf_fetched_o, 32'd0);
    check("t6_stall_clr", perf_stall_o, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
